// File: rtl/pipe_hs_ctrl.sv
`default_nettype none
// pipe_hs_ctrl: valid/allowin handshake, inter-stage latch enables, flush handling
// and retire/stall/flush performance counters for the IF-ID-EXE-MEM-WB pipeline.
module pipe_hs_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             fetch_valid_i,
    input  logic [4:0]       ready_go_i,
    input  logic             br_flush_i,
    input  logic             ex_flush_i,
    input  logic             cnt_clr_i,
    output logic [4:0]       valid_o,
    output logic [4:0]       allowin_o,
    output logic [4:0]       le_o,
    output logic [CNT_W-1:0] retire_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    logic [4:0]       valid;
    logic [4:0]       valid_nxt;
    logic [4:0]       allowin;
    logic [4:0]       tnv;
    logic [4:0]       le;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             retire_ev;
    logic             stall_ev;
    logic             flush_ev;

    assign tnv = valid & ready_go_i;

    // Backpressure ripples from WB toward IF within the same cycle.
    always_comb begin
        allowin    = '0;
        allowin[4] = !valid[4] | ready_go_i[4];
        for (int s = 3; s >= 0; s--) begin
            allowin[s] = !valid[s] | (ready_go_i[s] & allowin[s+1]);
        end
    end

    always_comb begin
        le    = '0;
        le[0] = fetch_valid_i & allowin[0];
        for (int s = 1; s < 5; s++) begin
            le[s] = tnv[s-1] & allowin[s];
        end
        if (br_flush_i) le[2:0] = '0;
        if (ex_flush_i) le = '0;
        // In-flight work is being discarded, so no downstream register may load.
        if (!rst_n) le[4:1] = '0;
    end

    always_comb begin
        valid_nxt    = '0;
        valid_nxt[0] = allowin[0] ? fetch_valid_i : valid[0];
        for (int s = 1; s < 5; s++) begin
            valid_nxt[s] = allowin[s] ? tnv[s-1] : valid[s];
        end
        if (br_flush_i) begin
            valid_nxt[1:0] = 2'b00;
            valid_nxt[2]   = allowin[2] ? 1'b0 : valid[2];
        end
        if (ex_flush_i) valid_nxt = '0;
    end

    assign retire_ev = valid[4] & ready_go_i[4] & !ex_flush_i;
    assign stall_ev  = valid[0] & !(ready_go_i[0] & allowin[1]);
    assign flush_ev  = br_flush_i | ex_flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid      <= '0;
            retire_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            valid <= valid_nxt;
            if (cnt_clr_i) begin
                retire_cnt <= '0;
                stall_cnt  <= '0;
                flush_cnt  <= '0;
            end else begin
                if (retire_ev) retire_cnt <= retire_cnt + CNT_W'(1);
                if (stall_ev)  stall_cnt  <= stall_cnt + CNT_W'(1);
                if (flush_ev)  flush_cnt  <= flush_cnt + CNT_W'(1);
            end
        end
    end

    assign valid_o      = valid;
    assign allowin_o    = allowin;
    assign le_o         = le;
    assign retire_cnt_o = retire_cnt;
    assign stall_cnt_o  = stall_cnt;
    assign flush_cnt_o  = flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hs_ctrl.sv
`default_nettype none
// Directed self-checking bench for pipe_hs_ctrl; a narrow-counter copy exercises wrap.
module tb_pipe_hs_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_valid_i;
    logic [4:0]  ready_go_i;
    logic        br_flush_i;
    logic        ex_flush_i;
    logic        cnt_clr_i;
    logic [4:0]  valid_o, allowin_o, le_o;
    logic [31:0] retire_cnt_o, stall_cnt_o, flush_cnt_o;
    logic [4:0]  n_valid, n_allowin, n_le;
    logic [2:0]  n_retire, n_stall, n_flush;

    int vec = 0;
    int err = 0;

    always #5 clk = ~clk;

    pipe_hs_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid_i), .ready_go_i(ready_go_i),
        .br_flush_i(br_flush_i), .ex_flush_i(ex_flush_i), .cnt_clr_i(cnt_clr_i),
        .valid_o(valid_o), .allowin_o(allowin_o), .le_o(le_o),
        .retire_cnt_o(retire_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_hs_ctrl #(.CNT_W(3)) dut_narrow (
        .clk(clk), .rst_n(rst_n), .fetch_valid_i(fetch_valid_i), .ready_go_i(ready_go_i),
        .br_flush_i(br_flush_i), .ex_flush_i(ex_flush_i), .cnt_clr_i(cnt_clr_i),
        .valid_o(n_valid), .allowin_o(n_allowin), .le_o(n_le),
        .retire_cnt_o(n_retire), .stall_cnt_o(n_stall), .flush_cnt_o(n_flush)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_valid_i = 1'b0; ready_go_i = 5'b11111;
        br_flush_i = 1'b0; ex_flush_i = 1'b0; cnt_clr_i = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic fill();
        fetch_valid_i = 1'b1; ready_go_i = 5'b11111;
        repeat (5) cyc();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_valid_i = 1'b1; ready_go_i = 5'b11111;
        br_flush_i = 1'b0; ex_flush_i = 1'b0; cnt_clr_i = 1'b0;
        cyc();
        vec++; if (valid_o !== 5'b00000) begin err++; $display("FAIL rst_valid got %b want 00000", valid_o); end
        vec++; if (allowin_o !== 5'b11111) begin err++; $display("FAIL rst_allowin got %b want 11111", allowin_o); end
        vec++; if (le_o !== 5'b00001) begin err++; $display("FAIL rst_le got %b want 00001", le_o); end
        vec++; if ({retire_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin err++;
            $display("FAIL rst_cnt got %0d/%0d/%0d want 0/0/0", retire_cnt_o, stall_cnt_o, flush_cnt_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_streaming();
        do_reset();
        fetch_valid_i = 1'b1; ready_go_i = 5'b11111;
        #1;
        vec++; if (le_o !== 5'b00001) begin err++; $display("FAIL strm_le0 got %b want 00001", le_o); end
        for (int i = 1; i <= 11; i++) begin
            cyc();
            if (i == 1) begin
                vec++; if (valid_o !== 5'b00001) begin err++; $display("FAIL strm_valid1 got %b want 00001", valid_o); end
            end
            if (i == 5) begin
                vec++; if (valid_o !== 5'b11111) begin err++; $display("FAIL strm_valid5 got %b want 11111", valid_o); end
                vec++; if (le_o !== 5'b11111) begin err++; $display("FAIL strm_le5 got %b want 11111", le_o); end
                vec++; if (retire_cnt_o !== 32'd0) begin err++; $display("FAIL strm_ret5 got %0d want 0", retire_cnt_o); end
            end
        end
        vec++; if (retire_cnt_o !== 32'd6) begin err++; $display("FAIL strm_ret11 got %0d want 6", retire_cnt_o); end
        vec++; if (stall_cnt_o !== 32'd0) begin err++; $display("FAIL strm_stall got %0d want 0", stall_cnt_o); end
    endtask

    task automatic test_mem_stall();
        do_reset();
        fill();
        ready_go_i = 5'b10111;
        #1;
        vec++; if (allowin_o !== 5'b10000) begin err++; $display("FAIL mst_allowin got %b want 10000", allowin_o); end
        vec++; if (le_o !== 5'b00000) begin err++; $display("FAIL mst_le got %b want 00000", le_o); end
        for (int k = 1; k <= 3; k++) begin
            cyc();
            vec++; if (valid_o !== 5'b01111) begin err++; $display("FAIL mst_valid%0d got %b want 01111", k, valid_o); end
            vec++; if (allowin_o !== 5'b10000) begin err++; $display("FAIL mst_allow%0d got %b want 10000", k, allowin_o); end
            vec++; if (stall_cnt_o !== 32'(k)) begin err++; $display("FAIL mst_stall%0d got %0d want %0d", k, stall_cnt_o, k); end
        end
        vec++; if (retire_cnt_o !== 32'd1) begin err++; $display("FAIL mst_ret got %0d want 1", retire_cnt_o); end
        ready_go_i = 5'b11111;
        #1;
        vec++; if (le_o !== 5'b11111) begin err++; $display("FAIL mst_rel_le got %b want 11111", le_o); end
        cyc();
        vec++; if (valid_o !== 5'b11111) begin err++; $display("FAIL mst_rel_valid got %b want 11111", valid_o); end
        vec++; if (stall_cnt_o !== 32'd3) begin err++; $display("FAIL mst_rel_stall got %0d want 3", stall_cnt_o); end
    endtask

    task automatic test_branch_flush();
        do_reset();
        fill();
        br_flush_i = 1'b1;
        #1;
        vec++; if (le_o !== 5'b11000) begin err++; $display("FAIL br_le got %b want 11000", le_o); end
        cyc();
        br_flush_i = 1'b0;
        vec++; if (valid_o !== 5'b11000) begin err++; $display("FAIL br_valid got %b want 11000", valid_o); end
        vec++; if (flush_cnt_o !== 32'd1) begin err++; $display("FAIL br_flush_cnt got %0d want 1", flush_cnt_o); end
        vec++; if (retire_cnt_o !== 32'd1) begin err++; $display("FAIL br_ret got %0d want 1", retire_cnt_o); end
        cyc();
        vec++; if (valid_o !== 5'b10001) begin err++; $display("FAIL br_after got %b want 10001", valid_o); end
        vec++; if (retire_cnt_o !== 32'd2) begin err++; $display("FAIL br_ret2 got %0d want 2", retire_cnt_o); end
    endtask

    task automatic test_ex_flush();
        do_reset();
        fill();
        ex_flush_i = 1'b1; br_flush_i = 1'b1;
        #1;
        vec++; if (le_o !== 5'b00000) begin err++; $display("FAIL ex_le got %b want 00000", le_o); end
        cyc();
        ex_flush_i = 1'b0; br_flush_i = 1'b0;
        vec++; if (valid_o !== 5'b00000) begin err++; $display("FAIL ex_valid got %b want 00000", valid_o); end
        vec++; if (retire_cnt_o !== 32'd0) begin err++; $display("FAIL ex_ret got %0d want 0", retire_cnt_o); end
        vec++; if (flush_cnt_o !== 32'd1) begin err++; $display("FAIL ex_flush_cnt got %0d want 1", flush_cnt_o); end
        vec++; if (allowin_o !== 5'b11111) begin err++; $display("FAIL ex_allowin got %b want 11111", allowin_o); end
    endtask

    task automatic test_clr_wrap();
        do_reset();
        fill();
        repeat (7) cyc();
        vec++; if (n_retire !== 3'd7) begin err++; $display("FAIL wrap_pre got %0d want 7", n_retire); end
        cyc();
        vec++; if (n_retire !== 3'd0) begin err++; $display("FAIL wrap got %0d want 0", n_retire); end
        vec++; if (retire_cnt_o !== 32'd8) begin err++; $display("FAIL wrap_main got %0d want 8", retire_cnt_o); end
        cnt_clr_i = 1'b1;
        cyc();
        cnt_clr_i = 1'b0;
        vec++; if (retire_cnt_o !== 32'd0) begin err++; $display("FAIL clr_ret got %0d want 0", retire_cnt_o); end
        vec++; if (n_retire !== 3'd0) begin err++; $display("FAIL clr_narrow got %0d want 0", n_retire); end
        cyc();
        vec++; if (retire_cnt_o !== 32'd1) begin err++; $display("FAIL clr_resume got %0d want 1", retire_cnt_o); end
    endtask

    task automatic test_reset_midstream();
        logic [4:0] pat;
        pat = 5'b01101;
        ready_go_i = 5'b11111;
        for (int i = 0; i < 5; i++) begin
            fetch_valid_i = pat[i];
            cyc();
        end
        vec++; if (valid_o !== 5'b10110) begin err++; $display("FAIL mid_valid got %b want 10110", valid_o); end
        vec++; if (retire_cnt_o !== 32'd6) begin err++; $display("FAIL mid_ret got %0d want 6", retire_cnt_o); end
        rst_n = 1'b0; fetch_valid_i = 1'b0;
        #1;
        vec++; if (le_o !== 5'b00000) begin err++; $display("FAIL mid_le got %b want 00000", le_o); end
        cyc();
        vec++; if (valid_o !== 5'b00000) begin err++; $display("FAIL mid_rst_valid got %b want 00000", valid_o); end
        vec++; if (allowin_o !== 5'b11111) begin err++; $display("FAIL mid_rst_allowin got %b want 11111", allowin_o); end
        vec++; if ({retire_cnt_o, stall_cnt_o, flush_cnt_o} !== 96'd0) begin err++;
            $display("FAIL mid_rst_cnt got %0d/%0d/%0d want 0/0/0", retire_cnt_o, stall_cnt_o, flush_cnt_o); end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_valid_i = 1'b0; ready_go_i = 5'b11111;
        br_flush_i = 1'b0; ex_flush_i = 1'b0; cnt_clr_i = 1'b0;
        test_reset();
        test_streaming();
        test_mem_stall();
        test_branch_flush();
        test_ex_flush();
        test_clr_wrap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
`default_nettype wire
